// File: rtl/prbs_pkg.sv
// Shared types, defaults and the word step function for the PRBS7 BIST block.
package prbs_pkg;
  localparam int PRBS_W  = 24;
  localparam int PRBS_T1 = 6;
  localparam int PRBS_T2 = 5;
  localparam int MAX_W   = 64;
  localparam logic [MAX_W-1:0] PRBS_SEED = 64'd1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

  // Advance w LFSR steps; only bits [w-1:0] of the result are meaningful.
  function automatic logic [MAX_W-1:0] prbs_step(input logic [MAX_W-1:0] x,
                                                 input int w, input int t1, input int t2);
    logic [MAX_W-1:0] s, f;
    s = x;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) begin
        f = (s >> t1) ^ (s >> t2);
        s = {s[MAX_W-2:0], f[0]};
      end
    end
    return s;
  endfunction
endpackage

// File: rtl/prbs_bist_ctrl_if.sv
// Link-side bus of the PRBS BIST controller. bit_err_cnt exists only with PRBS_BIT_ERR_EN.
interface prbs_bist_ctrl_if #(parameter int WIDTH = 24, parameter int CNT_W = 16);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] num_words;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             busy;
  logic             done;
  logic             locked;
  logic [CNT_W-1:0] err_cnt;
`ifdef PRBS_BIT_ERR_EN
  logic [CNT_W-1:0] bit_err_cnt;
  modport master (output start, abort, num_words, rx_data, rx_valid,
                  input  tx_data, tx_valid, busy, done, locked, err_cnt, bit_err_cnt);
  modport slave  (input  start, abort, num_words, rx_data, rx_valid,
                  output tx_data, tx_valid, busy, done, locked, err_cnt, bit_err_cnt);
`else
  modport master (output start, abort, num_words, rx_data, rx_valid,
                  input  tx_data, tx_valid, busy, done, locked, err_cnt);
  modport slave  (input  start, abort, num_words, rx_data, rx_valid,
                  output tx_data, tx_valid, busy, done, locked, err_cnt);
`endif
endinterface

// File: rtl/prbs_word_gen.sv
// Word-parallel PRBS generator: load emits the first word after the seed, adv steps once.
module prbs_word_gen import prbs_pkg::*; #(
  parameter int WIDTH = PRBS_W,
  parameter int TAP1  = PRBS_T1,
  parameter int TAP2  = PRBS_T2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             adv,
  output logic [WIDTH-1:0] word
);
  localparam logic [WIDTH-1:0] SEED = WIDTH'(PRBS_SEED);

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x);
    return WIDTH'(prbs_step(MAX_W'(x), WIDTH, TAP1, TAP2));
  endfunction

  // Loading straight to S(seed) makes the first RUN cycle carry word one.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)    word <= SEED;
    else if (load) word <= step(SEED);
    else if (adv)  word <= step(word);
endmodule

// File: rtl/prbs_bist_ctrl.sv
// PRBS7 BIST sequencer: tx stream, self-synchronising rx checker, lock/error status.
// Optional PRBS_BIT_ERR_EN adds a saturating per-bit error count.
module prbs_bist_ctrl import prbs_pkg::*; #(
  parameter int WIDTH     = PRBS_W,
  parameter int TAP1      = PRBS_T1,
  parameter int TAP2      = PRBS_T2,
  parameter int CNT_W     = 16,
  parameter int LOCK_GOOD = 4,
  parameter int DRAIN_MAX = 64
) (
  input logic            clk,
  input logic            rst_n,
  prbs_bist_ctrl_if.slave bus
);
  localparam int DR_W = $clog2(DRAIN_MAX + 1);
  localparam int MC_W = $clog2(LOCK_GOOD + 1);

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x);
    return WIDTH'(prbs_step(MAX_W'(x), WIDTH, TAP1, TAP2));
  endfunction

  state_e           state, state_nxt;
  logic [CNT_W-1:0] nw_q, tx_cnt, rx_cnt, err_q;
  logic [DR_W-1:0]  drain_cnt;
  logic [MC_W-1:0]  match_cnt;
  logic [WIDTH-1:0] expected, tx_word;
  logic             locked_q, load, last_word, rx_hit, chk;

  assign load      = bus.start && !bus.abort && (state == ST_IDLE || state == ST_DONE)
                     && (bus.num_words != '0);
  assign last_word = (tx_cnt == nw_q - CNT_W'(1));
  assign rx_hit    = (bus.rx_data == expected);
  // Abort freezes the checker on its own cycle so results are held exactly.
  assign chk       = (state == ST_RUN || state == ST_DRAIN) && bus.rx_valid && !bus.abort;

  prbs_word_gen #(.WIDTH(WIDTH), .TAP1(TAP1), .TAP2(TAP2)) u_gen (
    .clk, .rst_n, .load, .adv(state == ST_RUN), .word(tx_word)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    if (bus.abort) state_nxt = ST_IDLE;
    else case (state)
      ST_IDLE, ST_DONE:
        if (bus.start) state_nxt = (bus.num_words != '0) ? ST_RUN : ST_DONE;
      ST_RUN:   if (last_word) state_nxt = ST_DRAIN;
      ST_DRAIN: if (rx_cnt == nw_q || drain_cnt == DR_W'(DRAIN_MAX - 1)) state_nxt = ST_DONE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.tx_valid = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    case (state)
      ST_RUN:   begin bus.tx_valid = 1'b1; bus.busy = 1'b1; end
      ST_DRAIN: bus.busy = 1'b1;
      ST_DONE:  bus.done = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      nw_q <= '0; tx_cnt <= '0; rx_cnt <= '0; err_q <= '0;
      drain_cnt <= '0; match_cnt <= '0; expected <= '0; locked_q <= 1'b0;
    end else if (load) begin
      nw_q <= bus.num_words; tx_cnt <= '0; rx_cnt <= '0; err_q <= '0;
      drain_cnt <= '0; match_cnt <= '0; expected <= '0; locked_q <= 1'b0;
    end else begin
      if (state == ST_RUN)   tx_cnt    <= tx_cnt + CNT_W'(1);
      if (state == ST_DRAIN) drain_cnt <= drain_cnt + DR_W'(1);
      if (chk) begin
        if (locked_q) begin
          // Once locked the checker free-runs; rx_data only scores errors.
          expected <= step(expected);
          rx_cnt   <= rx_cnt + CNT_W'(1);
          if (!rx_hit && err_q != '1) err_q <= err_q + CNT_W'(1);
        end else begin
          expected <= step(bus.rx_data);
          if (rx_hit) begin
            match_cnt <= match_cnt + MC_W'(1);
            if (match_cnt == MC_W'(LOCK_GOOD - 1)) locked_q <= 1'b1;
          end else begin
            match_cnt <= '0;
          end
        end
      end
    end

`ifdef PRBS_BIT_ERR_EN
  localparam int SW = CNT_W + $clog2(WIDTH + 1);
  logic [CNT_W-1:0] bit_err_q;
  logic [SW-1:0]    be_sum;
  assign be_sum = SW'(bit_err_q) + SW'($countones(bus.rx_data ^ expected));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                bit_err_q <= '0;
    else if (load)             bit_err_q <= '0;
    else if (chk && locked_q)  bit_err_q <= (be_sum > SW'({CNT_W{1'b1}})) ? '1 : be_sum[CNT_W-1:0];

  assign bus.bit_err_cnt = bit_err_q;
`endif

  assign bus.tx_data = tx_word;
  assign bus.locked  = locked_q;
  assign bus.err_cnt = err_q;
endmodule

// File: tb/tb_prbs_bist_ctrl.sv
// Directed bench for prbs_bist_ctrl: a 16-bit-count instance plus a 4-bit-count one for saturation.
module tb_prbs_bist_ctrl;
  localparam int W = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prbs_bist_ctrl_if #(.WIDTH(W), .CNT_W(16)) a ();
  prbs_bist_ctrl_if #(.WIDTH(W), .CNT_W(4))  b ();

  prbs_bist_ctrl #(.WIDTH(W), .CNT_W(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(a));
  prbs_bist_ctrl #(.WIDTH(W), .CNT_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(b));

  // Loopback path for instance a, with a per-word corruption mask.
  logic         lb;
  logic [W-1:0] flip;
  assign a.rx_data  = lb ? (a.tx_data ^ flip) : '0;
  assign a.rx_valid = lb & a.tx_valid;

  int n_cmp = 0;
  int n_bad = 0;
  int ntx, t_last, t_done, t_lock, nv;
  logic [W-1:0] w1, w2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] tb_step(input logic [W-1:0] x);
    logic [W-1:0] s;
    s = x;
    repeat (W) s = {s[W-2:0], s[6] ^ s[5]};
    return s;
  endfunction

  task automatic run_a(input int nw, input int fa, input int fb, input int restart);
    ntx = 0; t_last = -1; t_done = -1; t_lock = -1; flip = '0;
    a.num_words = 16'(nw); a.start = 1'b1;
    @(negedge clk);
    a.start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      flip = '0;
      if (a.tx_valid) begin
        ntx++; t_last = i;
        if (ntx == 1) w1 = a.tx_data;
        if (ntx == 2) w2 = a.tx_data;
        if (ntx == fa || ntx == fb) flip = W'(8);
      end
      if (a.locked && t_lock < 0) t_lock = i;
      if (a.done) begin t_done = i; break; end
      if (i == restart) begin a.start = 1'b1; a.num_words = 16'd3; end
      else a.start = 1'b0;
      @(negedge clk);
    end
    a.start = 1'b0;
    chk("done_seen", 32'(t_done >= 0), 1);
  endtask

  task automatic run_b(input int abort_at);
    logic [W-1:0] mw;
    mw = tb_step(W'(1));
    t_done = -1;
    b.num_words = 4'd15; b.start = 1'b1;
    @(negedge clk);
    b.start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (b.done) begin t_done = i; break; end
      if (abort_at < 0 && i == 19) chk("sat_pre", b.err_cnt, 14);
      if (abort_at >= 0 && i == abort_at) begin
        chk("abort_busy", b.busy, 1);
        chk("abort_err_pre", b.err_cnt, 12);
        b.abort = 1'b1;
      end
      if (abort_at >= 0 && i == abort_at + 1) begin
        b.abort = 1'b0;
        chk("abort_busy_off", b.busy, 0);
        chk("abort_done_off", b.done, 0);
        chk("abort_txv", b.tx_valid, 0);
        chk("abort_locked", b.locked, 1);
        chk("abort_err", b.err_cnt, 12);
      end
      if (abort_at >= 0 && i == abort_at + 4) begin
        chk("abort_hold", b.err_cnt, 12);
        break;
      end
      b.rx_valid = 1'b1;
      b.rx_data  = (i < 5) ? mw : ~mw;
      mw = tb_step(mw);
      @(negedge clk);
    end
    b.rx_valid = 1'b0;
    b.abort    = 1'b0;
  endtask

  initial begin
    a.start = 1'b0; a.abort = 1'b0; a.num_words = '0;
    b.start = 1'b0; b.abort = 1'b0; b.num_words = '0;
    b.rx_valid = 1'b0; b.rx_data = '0;
    lb = 1'b1; flip = '0;

    repeat (2) @(negedge clk);
    chk("rst_txd", a.tx_data, 1);
    chk("rst_txv", a.tx_valid, 0);
    chk("rst_busy", a.busy, 0);
    chk("rst_done", a.done, 0);
    chk("rst_locked", a.locked, 0);
    chk("rst_err", a.err_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of a 100-word run, at word 10.
    a.num_words = 16'd100; a.start = 1'b1;
    @(negedge clk);
    a.start = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_txv", a.tx_valid, 1);
    chk("mid_locked", a.locked, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_txv", a.tx_valid, 0);
    chk("arst_txd", a.tx_data, 1);
    chk("arst_busy", a.busy, 0);
    chk("arst_locked", a.locked, 0);
    chk("arst_err", a.err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    repeat (5) begin @(negedge clk); if (a.tx_valid) nv++; end
    chk("post_rst_txv", nv, 0);

    // Clean loopback.
    run_a(50, -1, -1, -1);
    chk("lb_ntx", ntx, 50);
    chk("lb_w1", w1, 32'h061479);
    chk("lb_w2", w2, tb_step(w1));
    chk("lb_lock_time", 32'(t_lock >= 4 && t_lock <= 6), 1);
    chk("lb_drain_len", t_done - t_last, 65);
    chk("lb_err", a.err_cnt, 0);
    chk("lb_locked", a.locked, 1);
    chk("lb_busy", a.busy, 0);
`ifdef PRBS_BIT_ERR_EN
    chk("lb_bit_err", a.bit_err_cnt, 0);
`endif

    // Bit 3 flipped on words 20 and 30.
    run_a(50, 20, 30, -1);
    chk("flip_err", a.err_cnt, 2);
`ifdef PRBS_BIT_ERR_EN
    chk("flip_bit_err", a.bit_err_cnt, 2);
`endif

    // No returned words: never locks, drain times out.
    lb = 1'b0;
    run_a(10, -1, -1, -1);
    chk("quiet_ntx", ntx, 10);
    chk("quiet_drain_len", t_done - t_last, 65);
    chk("quiet_locked", a.locked, 0);
    chk("quiet_err", a.err_cnt, 0);
    lb = 1'b1;

    // Zero-length test, then a start ignored while busy.
    run_a(0, -1, -1, -1);
    chk("nw0_done_time", t_done, 0);
    chk("nw0_ntx", ntx, 0);
    run_a(20, -1, -1, 5);
    chk("restart_ntx", ntx, 20);

    // 4-bit counters: error count saturates, then abort in DRAIN holds results.
    run_b(-1);
    chk("sat_done_time", t_done, 21);
    chk("sat_err", b.err_cnt, 15);
    chk("sat_locked", b.locked, 1);
`ifdef PRBS_BIT_ERR_EN
    chk("sat_bit_err", b.bit_err_cnt, 15);
`endif
    run_b(17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
